// File: rtl/pipe_stall_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// pipe_stall_ctrl_pkg
// Shared definitions for the pipeline hazard controller:
//   StallBus          - 6-bit stall bus type (bit0 PC .. bit5 WB)
//   Stop / NoStop     - per-stage encoding on the stall bus
//   STALL_NONE/LOAD/EX - the stall patterns driven onto the bus
//   stall_state_e     - hazard FSM state encoding
// -----------------------------------------------------------------------------
package pipe_stall_ctrl_pkg;

    typedef logic [5:0] StallBus;

    localparam logic Stop   = 1'b1;
    localparam logic NoStop = 1'b0;

    // Bit order is {WB, MEM, EX, ID, IF, PC}
    localparam StallBus STALL_NONE = {6{NoStop}};
    // Hold PC..ID and insert a bubble into EX.
    localparam StallBus STALL_LOAD = {NoStop, NoStop, NoStop, Stop, Stop, Stop};
    // Hold PC..EX and insert a bubble into MEM.
    localparam StallBus STALL_EX   = {NoStop, NoStop, Stop, Stop, Stop, Stop};

    typedef enum logic [1:0] {
        ST_RUN           = 2'd0,
        ST_LOAD_STALL    = 2'd1,
        ST_EX_STALL      = 2'd2,
        ST_FLUSH_RECOVER = 2'd3
    } stall_state_e;

endpackage

// File: rtl/pipe_stall_ctrl_sat_counter.sv
// -----------------------------------------------------------------------------
// sat_counter
// Up-counter that sticks at all-ones instead of wrapping.
// Ports:
//   clk   - clock
//   rst   - asynchronous active-low reset, clears the count
//   inc   - increment request for this cycle
//   count - current count (W bits)
// -----------------------------------------------------------------------------
module sat_counter #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         inc,
    output logic [W-1:0] count
);

    logic [W-1:0] count_reg;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count_reg <= '0;
        end else if (inc && (count_reg != {W{1'b1}})) begin
            count_reg <= count_reg + W'(1);
        end
    end

    assign count = count_reg;

endmodule

// File: rtl/pipe_stall_ctrl.sv
// -----------------------------------------------------------------------------
// pipe_stall_ctrl
// Hazard controller for the five-stage core. Merges load-use, EX busy and MEM
// flush requests into the shared stall bus plus flush/redirect, tracks stall
// episodes in a small FSM, runs an EX-stall watchdog and flags repeated
// load-use stalls.
//
// Optional feature macro: STALL_PERF_CNT_EN -- when defined, three saturating
// performance counters are built; otherwise the counter outputs read 0.
//
// Ports:
//   clk             - core clock
//   rst             - asynchronous active-low reset
//   stall_for_load  - load-use hazard request from ID
//   stallreq_for_ex - EX multi-cycle unit busy
//   flush_req       - flush pulse from MEM
//   flush_pc        - redirect target, valid with flush_req
//   stall           - stall bus (bit0 PC .. bit5 WB), combinational
//   flush           - squash all stage registers, combinational
//   new_pc          - redirect PC, combinational
//   stall_timeout   - sticky: EX stall lasted MAX_EX_STALL cycles
//   load_stall_err  - sticky: load-use stall repeated back to back
//   load_stall_cnt  - cycles that drove the load stall pattern
//   ex_stall_cnt    - cycles that drove the EX stall pattern
//   flush_cnt       - flush cycles
// -----------------------------------------------------------------------------
module pipe_stall_ctrl
    import pipe_stall_ctrl_pkg::*;
#(
    parameter int MAX_EX_STALL = 64,
    parameter int CNT_W        = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             stall_for_load,
    input  logic             stallreq_for_ex,
    input  logic             flush_req,
    input  logic [31:0]      flush_pc,
    output StallBus          stall,
    output logic             flush,
    output logic [31:0]      new_pc,
    output logic             stall_timeout,
    output logic             load_stall_err,
    output logic [CNT_W-1:0] load_stall_cnt,
    output logic [CNT_W-1:0] ex_stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    localparam int RUN_W = $clog2(MAX_EX_STALL + 1);
    localparam logic [RUN_W-1:0] RUN_MAX = RUN_W'(MAX_EX_STALL);

    stall_state_e     state_reg, state_next;
    logic [RUN_W-1:0] ex_run_reg, ex_run_next;
    logic             timeout_reg, timeout_next;
    logic             err_reg, err_next;

    logic load_masked;
    logic ex_active;

    // Squashed stage contents make a load-use request meaningless during the
    // recovery cycle right after a flush.
    assign load_masked = stall_for_load && (state_reg != ST_FLUSH_RECOVER);
    // A flush overrides an EX stall, so it also breaks the watchdog run.
    assign ex_active   = stallreq_for_ex && !flush_req;

    // ---------------- combinational outputs and next state ----------------
    always_comb begin
        stall      = STALL_NONE;
        flush      = 1'b0;
        new_pc     = 32'h0;
        state_next = ST_RUN;

        if (flush_req) begin
            flush      = 1'b1;
            new_pc     = flush_pc;
            state_next = ST_FLUSH_RECOVER;
        end else if (stallreq_for_ex) begin
            stall      = STALL_EX;
            state_next = ST_EX_STALL;
        end else if (load_masked) begin
            stall      = STALL_LOAD;
            state_next = ST_LOAD_STALL;
        end
    end

    // ---------------- watchdog and sticky flags ----------------
    always_comb begin
        ex_run_next  = '0;
        timeout_next = timeout_reg;
        err_next     = err_reg;

        if (ex_active) begin
            ex_run_next = (ex_run_reg == RUN_MAX) ? RUN_MAX : ex_run_reg + RUN_W'(1);
        end
        if (ex_run_next == RUN_MAX) begin
            timeout_next = 1'b1;
        end

        // Back-to-back load-use stall: ID should have been resolved by now.
        if ((state_reg == ST_LOAD_STALL) && stall_for_load && !stallreq_for_ex) begin
            err_next = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg   <= ST_RUN;
            ex_run_reg  <= '0;
            timeout_reg <= 1'b0;
            err_reg     <= 1'b0;
        end else begin
            state_reg   <= state_next;
            ex_run_reg  <= ex_run_next;
            timeout_reg <= timeout_next;
            err_reg     <= err_next;
        end
    end

    assign stall_timeout  = timeout_reg;
    assign load_stall_err = err_reg;

    // ---------------- performance counters ----------------
`ifdef STALL_PERF_CNT_EN
    logic [2:0]       cnt_inc;
    logic [CNT_W-1:0] cnt_val [3];

    // Increment exactly when the corresponding pattern is on the bus.
    assign cnt_inc[0] = !flush_req && !stallreq_for_ex && load_masked;
    assign cnt_inc[1] = ex_active;
    assign cnt_inc[2] = flush_req;

    generate
        for (genvar gi = 0; gi < 3; gi++) begin : g_cnt
            sat_counter #(
                .W (CNT_W)
            ) u_cnt (
                .clk   (clk),
                .rst   (rst),
                .inc   (cnt_inc[gi]),
                .count (cnt_val[gi])
            );
        end
    endgenerate

    assign load_stall_cnt = cnt_val[0];
    assign ex_stall_cnt   = cnt_val[1];
    assign flush_cnt      = cnt_val[2];
`else
    assign load_stall_cnt = '0;
    assign ex_stall_cnt   = '0;
    assign flush_cnt      = '0;
`endif

endmodule

// File: tb/tb_pipe_stall_ctrl.sv
// -----------------------------------------------------------------------------
// tb_pipe_stall_ctrl
// Directed self-checking bench for pipe_stall_ctrl (MAX_EX_STALL = 8).
// Counter expectations follow STALL_PERF_CNT_EN: the bench tracks the expected
// counts from its own stimulus and expects 0 when the macro is undefined.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_pipe_stall_ctrl;

`ifdef STALL_PERF_CNT_EN
    localparam bit PERF = 1'b1;
`else
    localparam bit PERF = 1'b0;
`endif

    localparam int CNT_W = 32;

    logic             clk;
    logic             rst;
    logic             stall_for_load;
    logic             stallreq_for_ex;
    logic             flush_req;
    logic [31:0]      flush_pc;
    logic [5:0]       stall;
    logic             flush;
    logic [31:0]      new_pc;
    logic             stall_timeout;
    logic             load_stall_err;
    logic [CNT_W-1:0] load_stall_cnt;
    logic [CNT_W-1:0] ex_stall_cnt;
    logic [CNT_W-1:0] flush_cnt;

    int total = 0;
    int bad   = 0;
    int exp_load  = 0;
    int exp_ex    = 0;
    int exp_flush = 0;

    pipe_stall_ctrl #(
        .MAX_EX_STALL (8),
        .CNT_W        (CNT_W)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .stall_for_load  (stall_for_load),
        .stallreq_for_ex (stallreq_for_ex),
        .flush_req       (flush_req),
        .flush_pc        (flush_pc),
        .stall           (stall),
        .flush           (flush),
        .new_pc          (new_pc),
        .stall_timeout   (stall_timeout),
        .load_stall_err  (load_stall_err),
        .load_stall_cnt  (load_stall_cnt),
        .ex_stall_cnt    (ex_stall_cnt),
        .flush_cnt       (flush_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end else begin
            $display("ok   %s val=%0h t=%0t", tag, got, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_cnts(input string tag);
        check({tag, ".load_cnt"},  64'(load_stall_cnt), PERF ? 64'(exp_load)  : 64'd0);
        check({tag, ".ex_cnt"},    64'(ex_stall_cnt),   PERF ? 64'(exp_ex)    : 64'd0);
        check({tag, ".flush_cnt"}, 64'(flush_cnt),      PERF ? 64'(exp_flush) : 64'd0);
    endtask

    // Run stallreq_for_ex for n cycles, checking the bus each cycle.
    task automatic ex_burst(input int n, input string tag);
        stallreq_for_ex = 1'b1;
        for (int i = 0; i < n; i++) begin
            #1;
            check({tag, ".stall"}, 64'(stall), 64'h0f);
            step();
            exp_ex++;
        end
        stallreq_for_ex = 1'b0;
    endtask

    initial begin
        rst             = 1'b0;
        stall_for_load  = 1'b0;
        stallreq_for_ex = 1'b0;
        flush_req       = 1'b0;
        flush_pc        = 32'h0;

        // ---- reset state ----
        step();
        step();
        check("rst.stall",   64'(stall),          64'h00);
        check("rst.flush",   64'(flush),          64'd0);
        check("rst.new_pc",  64'(new_pc),         64'd0);
        check("rst.timeout", 64'(stall_timeout),  64'd0);
        check("rst.err",     64'(load_stall_err), 64'd0);
        check_cnts("rst");
        rst = 1'b1;
        step();

        // ---- single load-use stall from RUN ----
        stall_for_load = 1'b1;
        #1;
        check("load1.stall", 64'(stall), 64'h07);
        step();
        exp_load++;
        stall_for_load = 1'b0;
        #1;
        check("load1.stall_off", 64'(stall), 64'h00);
        check("load1.err",       64'(load_stall_err), 64'd0);
        check_cnts("load1");
        step();

        // ---- EX stall 5 cycles with load request overlapping ----
        stall_for_load = 1'b1;
        ex_burst(5, "ex5");
        stall_for_load = 1'b0;
        #1;
        check("ex5.err", 64'(load_stall_err), 64'd0);
        check_cnts("ex5");
        step();

        // ---- flush beats EX stall, then FLUSH_RECOVER masks load ----
        flush_req       = 1'b1;
        flush_pc        = 32'hBFC00380;
        stallreq_for_ex = 1'b1;
        #1;
        check("flush.flush",  64'(flush),  64'd1);
        check("flush.new_pc", 64'(new_pc), 64'hBFC00380);
        check("flush.stall",  64'(stall),  64'h00);
        step();
        exp_flush++;
        flush_req       = 1'b0;
        flush_pc        = 32'h0;
        stallreq_for_ex = 1'b0;
        stall_for_load  = 1'b1;
        #1;
        check("recov.stall",  64'(stall),  64'h00);
        check("recov.flush",  64'(flush),  64'd0);
        check("recov.new_pc", 64'(new_pc), 64'd0);
        step();
        stall_for_load = 1'b0;
        #1;
        check("recov.err", 64'(load_stall_err), 64'd0);
        check_cnts("recov");
        step();

        // ---- back-to-back load-use stalls raise sticky error ----
        stall_for_load = 1'b1;
        step();
        exp_load++;
        check("ll.err_first", 64'(load_stall_err), 64'd0);
        check("ll.stall2",    64'(stall),          64'h07);
        step();
        exp_load++;
        check("ll.err_second", 64'(load_stall_err), 64'd1);
        stall_for_load = 1'b0;
        step();
        step();
        check("ll.err_sticky", 64'(load_stall_err), 64'd1);
        check_cnts("ll");

        // ---- watchdog: 7 + gap + 7 must not trip ----
        ex_burst(7, "wd7a");
        step();
        ex_burst(7, "wd7b");
        check("wd7.timeout", 64'(stall_timeout), 64'd0);
        step();

        // ---- watchdog: 8 consecutive cycles trips on the 8th edge ----
        stallreq_for_ex = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            step();
            exp_ex++;
            check($sformatf("wd8.timeout_%0d", i), 64'(stall_timeout), (i == 8) ? 64'd1 : 64'd0);
        end
        stallreq_for_ex = 1'b0;
        step();
        check("wd8.sticky", 64'(stall_timeout), 64'd1);
        check_cnts("wd8");

        // ---- asynchronous reset in the middle of an EX stall ----
        stallreq_for_ex = 1'b1;
        step();
        step();
        step();
        #2;
        rst             = 1'b0;
        stallreq_for_ex = 1'b0;
        exp_load  = 0;
        exp_ex    = 0;
        exp_flush = 0;
        #1;
        check("arst.timeout", 64'(stall_timeout),  64'd0);
        check("arst.err",     64'(load_stall_err), 64'd0);
        check("arst.stall",   64'(stall),          64'h00);
        check_cnts("arst");
        step();
        rst = 1'b1;
        step();

        // Watchdog restarted: 7 more cycles must stay below the limit.
        ex_burst(7, "arst7");
        check("arst7.timeout", 64'(stall_timeout), 64'd0);
        check_cnts("arst7");
        step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
